// File: rtl/gdma_gtp_tx_framer.sv
// Turns the GDMA packager's packet stream into a continuous 32-bit GTP TX word stream:
// K-char delimited frames with a checksum, idle fill, and periodic clock-correction bursts.
module gdma_gtp_tx_framer #(
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_start,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [31:0] s_tdata,
  output logic [31:0] gtp_txdata,
  output logic [3:0]  gtp_txcharisk,
  output logic        frame_busy,
  output logic        frame_done,
  output logic [7:0]  frame_seq
);

  localparam int CCW = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam int CRW = $clog2(CC_LEN + 1);

  localparam logic [31:0] IDLE_WORD = 32'h50BC50BC;
  localparam logic [3:0]  IDLE_K    = 4'b0101;
  localparam logic [31:0] CC_WORD   = 32'h1C1C1C1C;
  localparam logic [3:0]  CC_K      = 4'b1111;
  localparam logic [31:0] EOF_WORD  = 32'h000000FD;
  localparam logic [3:0]  DELIM_K   = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SOF, ST_HDR0, ST_HDR1, ST_DATA, ST_CSUM, ST_EOF
  } state_t;

  state_t          state, state_nx;
  logic [31:0]     csum, csum_nx;
  logic [30:0]     cnt, cnt_nx;
  logic [7:0]      seq_nx;
  logic [31:0]     txd_nx;
  logic [3:0]      txk_nx;
  logic            busy_nx, done_nx;
  logic [CCW-1:0]  cc_cnt;
  logic [CRW-1:0]  cc_rem;
  logic            cc_active;
  logic            hs;

  assign cc_active = (cc_rem != '0);
  assign s_tready  = (state == ST_HDR0 || state == ST_HDR1 || state == ST_DATA)
                     && !cc_active && !rst;
  assign hs        = s_tvalid && s_tready;

  // Free-running CC scheduler; deliberately unaffected by op_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_cnt <= '0;
      cc_rem <= '0;
    end else if (cc_cnt == CCW'(CC_PERIOD - 1)) begin
      cc_cnt <= '0;
      cc_rem <= CRW'(CC_LEN);
    end else begin
      cc_cnt <= cc_cnt + CCW'(1);
      if (cc_active) cc_rem <= cc_rem - CRW'(1);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx = state;
    csum_nx  = csum;
    cnt_nx   = cnt;
    seq_nx   = frame_seq;
    txd_nx   = IDLE_WORD;
    txk_nx   = IDLE_K;
    busy_nx  = (state != ST_IDLE);
    done_nx  = 1'b0;

    if (op_start) begin
      state_nx = ST_IDLE;
      csum_nx  = '0;
      seq_nx   = '0;
      busy_nx  = 1'b0;
      if (cc_active) begin
        txd_nx = CC_WORD;
        txk_nx = CC_K;
      end
    end else if (cc_active) begin
      // CC freezes the frame state; it resumes exactly where it stopped.
      txd_nx = CC_WORD;
      txk_nx = CC_K;
    end else begin
      unique case (state)
        ST_IDLE: if (s_tvalid) state_nx = ST_SOF;
        ST_SOF: begin
          txd_nx   = {16'h0, frame_seq, 8'hFB};
          txk_nx   = DELIM_K;
          csum_nx  = '0;
          state_nx = ST_HDR0;
        end
        ST_HDR0, ST_HDR1, ST_DATA: begin
          if (hs) begin
            txd_nx  = s_tdata;
            txk_nx  = 4'b0000;
            csum_nx = csum + s_tdata;
            if (state == ST_HDR0) begin
              state_nx = ST_HDR1;
            end else if (state == ST_HDR1) begin
              cnt_nx   = s_tdata[30:0];
              state_nx = ST_DATA;
            end else if (cnt == '0) begin
              state_nx = ST_CSUM;
            end else begin
              cnt_nx = cnt - 31'd1;
            end
          end
        end
        ST_CSUM: begin
          txd_nx   = csum;
          txk_nx   = 4'b0000;
          state_nx = ST_EOF;
        end
        ST_EOF: begin
          txd_nx   = EOF_WORD;
          txk_nx   = DELIM_K;
          done_nx  = 1'b1;
          seq_nx   = frame_seq + 8'd1;
          state_nx = s_tvalid ? ST_SOF : ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state         <= ST_IDLE;
      csum          <= '0;
      cnt           <= '0;
      frame_seq     <= '0;
      gtp_txdata    <= IDLE_WORD;
      gtp_txcharisk <= IDLE_K;
      frame_busy    <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_nx;
      csum          <= csum_nx;
      cnt           <= cnt_nx;
      frame_seq     <= seq_nx;
      gtp_txdata    <= txd_nx;
      gtp_txcharisk <= txk_nx;
      frame_busy    <= busy_nx;
      frame_done    <= done_nx;
    end
  end

endmodule

// File: tb/tb_gdma_gtp_tx_framer.sv
// Directed bench for gdma_gtp_tx_framer: cycle tables for framing/stall/abort, plus
// streamed sequences for CC insertion and long back-to-back frame runs.
module tb_gdma_gtp_tx_framer;

  localparam logic [31:0] IDLE_W = 32'h50BC50BC;
  localparam logic [3:0]  IK     = 4'b0101;
  localparam logic [31:0] CC_W   = 32'h1C1C1C1C;
  localparam logic [31:0] EOF_W  = 32'h000000FD;
  localparam int B_PERIOD = 16;
  localparam int B_LEN    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, op_a, valid_a, ready_a, busy_a, done_a;
  logic [31:0] data_a, txd_a;
  logic [3:0]  k_a;
  logic [7:0]  seq_a;
  logic        rst_b, op_b, valid_b, ready_b, busy_b, done_b;
  logic [31:0] data_b, txd_b;
  logic [3:0]  k_b;
  logic [7:0]  seq_b;

  gdma_gtp_tx_framer #(.CC_PERIOD(100000), .CC_LEN(4)) dut_a (
    .clk(clk), .rst(rst_a), .op_start(op_a), .s_tvalid(valid_a), .s_tready(ready_a),
    .s_tdata(data_a), .gtp_txdata(txd_a), .gtp_txcharisk(k_a), .frame_busy(busy_a),
    .frame_done(done_a), .frame_seq(seq_a));

  gdma_gtp_tx_framer #(.CC_PERIOD(B_PERIOD), .CC_LEN(B_LEN)) dut_b (
    .clk(clk), .rst(rst_b), .op_start(op_b), .s_tvalid(valid_b), .s_tready(ready_b),
    .s_tdata(data_b), .gtp_txdata(txd_b), .gtp_txcharisk(k_b), .frame_busy(busy_b),
    .frame_done(done_b), .frame_seq(seq_b));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sof_w(input logic [7:0] s);
    return {16'h0, s, 8'hFB};
  endfunction

  typedef struct {
    logic        op;
    logic        valid;
    logic [31:0] data;
    logic        exp_ready;
    logic [31:0] exp_txd;
    logic [3:0]  exp_k;
    logic        exp_busy;
    logic        exp_done;
    logic [7:0]  exp_seq;
  } vec_t;

  function automatic vec_t mk(input logic op, input logic valid, input logic [31:0] data,
                              input logic rdy, input logic [31:0] txd, input logic [3:0] k,
                              input logic busy, input logic done, input logic [7:0] seq);
    vec_t v;
    v.op = op; v.valid = valid; v.data = data; v.exp_ready = rdy; v.exp_txd = txd;
    v.exp_k = k; v.exp_busy = busy; v.exp_done = done; v.exp_seq = seq;
    return v;
  endfunction

  // Streams npkt packets of length len into one DUT with valid always high and checks
  // the exact output word sequence; use_cc expects dut_b's CC bursts at fixed cycles.
  task automatic stream(input bit sel, input int npkt, input logic [30:0] len,
                        input bit use_cc, input int budget, input logic [7:0] final_seq);
    logic [31:0] words[$];
    logic [36:0] exp[$];
    logic [31:0] hdr0, hdr1, d, csum;
    int          wi = 0;
    int          dones = 0;
    bit          started = 0;
    bit          rdy, vld, hs, cc;
    logic [31:0] txd;
    logic [3:0]  k;
    logic        busy, done;
    for (int p = 0; p < npkt; p++) begin
      hdr0 = 32'h0100_0000 + 32'(p);
      hdr1 = {1'b1, len};
      csum = hdr0 + hdr1;
      words.push_back(hdr0);
      words.push_back(hdr1);
      exp.push_back({1'b1, sof_w(8'(p)), 4'b0001});
      exp.push_back({1'b1, hdr0, 4'b0000});
      exp.push_back({1'b1, hdr1, 4'b0000});
      for (int j = 0; j <= int'(len); j++) begin
        d = 32'hC000_0000 + (32'(p) << 8) + 32'(j);
        csum = csum + d;
        words.push_back(d);
        exp.push_back({1'b1, d, 4'b0000});
      end
      exp.push_back({1'b1, csum, 4'b0000});
      exp.push_back({1'b1, EOF_W, 4'b0001});
    end
    for (int n = 0; n < budget && exp.size() > 0; n++) begin
      vld = (wi < words.size());
      d   = vld ? words[wi] : 32'h0;
      if (sel) begin valid_b = vld; data_b = d; end
      else     begin valid_a = vld; data_a = d; end
      #1;
      rdy = sel ? ready_b : ready_a;
      hs  = rdy && vld;
      cc  = use_cc && n >= B_PERIOD && (n % B_PERIOD) < B_LEN;
      if (cc) check("cc_ready_low", 64'(rdy), 64'(0));
      @(posedge clk); #1;
      if (hs) wi++;
      txd  = sel ? txd_b  : txd_a;
      k    = sel ? k_b    : k_a;
      busy = sel ? busy_b : busy_a;
      done = sel ? done_b : done_a;
      if (done) dones++;
      if (cc) begin
        check("cc_word", {txd, k}, {CC_W, 4'hF});
      end else if (!started && txd == IDLE_W && k == IK) begin
        // leading idle before the first SOF
      end else begin
        started = 1;
        check("frame_word", {busy, txd, k}, exp.pop_front());
      end
    end
    check("stream_drained", 64'(exp.size()), 64'(0));
    check("done_count", 64'(dones), 64'(npkt));
    check("seq_after_stream", 64'(sel ? seq_b : seq_a), 64'(final_seq));
    if (sel) valid_b = 1'b0; else valid_a = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; op_a = 1'b0; op_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;

    // Test 2: straight packet, seq 0
    vecs.push_back(mk(0,1,32'h203,      0,IDLE_W,IK,0,0,0));
    vecs.push_back(mk(0,1,32'h203,      0,sof_w(0),4'b0001,1,0,0));
    vecs.push_back(mk(0,1,32'h203,      1,32'h203,0,1,0,0));
    vecs.push_back(mk(0,1,32'h2,        1,32'h2,0,1,0,0));
    vecs.push_back(mk(0,1,32'h11111111, 1,32'h11111111,0,1,0,0));
    vecs.push_back(mk(0,1,32'h22222222, 1,32'h22222222,0,1,0,0));
    vecs.push_back(mk(0,1,32'h33333333, 1,32'h33333333,0,1,0,0));
    vecs.push_back(mk(0,0,32'h0,        0,32'h6666686B,0,1,0,0));
    vecs.push_back(mk(0,0,32'h0,        0,EOF_W,4'b0001,1,1,1));
    vecs.push_back(mk(0,0,32'h0,        0,IDLE_W,IK,0,0,1));
    // Test 3: same packet with a 3-cycle stall after the 2nd data word, seq 1
    vecs.push_back(mk(0,1,32'h203,      0,IDLE_W,IK,0,0,1));
    vecs.push_back(mk(0,1,32'h203,      0,sof_w(1),4'b0001,1,0,1));
    vecs.push_back(mk(0,1,32'h203,      1,32'h203,0,1,0,1));
    vecs.push_back(mk(0,1,32'h2,        1,32'h2,0,1,0,1));
    vecs.push_back(mk(0,1,32'h11111111, 1,32'h11111111,0,1,0,1));
    vecs.push_back(mk(0,1,32'h22222222, 1,32'h22222222,0,1,0,1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,0,32'hDEADBEEF, 1,IDLE_W,IK,1,0,1));
    vecs.push_back(mk(0,1,32'h33333333, 1,32'h33333333,0,1,0,1));
    vecs.push_back(mk(0,0,32'h0,        0,32'h6666686B,0,1,0,1));
    vecs.push_back(mk(0,0,32'h0,        0,EOF_W,4'b0001,1,1,2));
    vecs.push_back(mk(0,0,32'h0,        0,IDLE_W,IK,0,0,2));
    // Test 5: op_start mid-DATA, then a clean L=0 frame restarting at seq 0
    vecs.push_back(mk(0,1,32'h105,      0,IDLE_W,IK,0,0,2));
    vecs.push_back(mk(0,1,32'h105,      0,sof_w(2),4'b0001,1,0,2));
    vecs.push_back(mk(0,1,32'h105,      1,32'h105,0,1,0,2));
    vecs.push_back(mk(0,1,32'h5,        1,32'h5,0,1,0,2));
    vecs.push_back(mk(0,1,32'hA,        1,32'hA,0,1,0,2));
    vecs.push_back(mk(1,1,32'hB,        1,IDLE_W,IK,0,0,0));
    vecs.push_back(mk(0,0,32'h0,        0,IDLE_W,IK,0,0,0));
    vecs.push_back(mk(0,1,32'hAAAA0001, 0,IDLE_W,IK,0,0,0));
    vecs.push_back(mk(0,1,32'hAAAA0001, 0,sof_w(0),4'b0001,1,0,0));
    vecs.push_back(mk(0,1,32'hAAAA0001, 1,32'hAAAA0001,0,1,0,0));
    vecs.push_back(mk(0,1,32'h0,        1,32'h0,0,1,0,0));
    vecs.push_back(mk(0,1,32'h5,        1,32'h5,0,1,0,0));
    vecs.push_back(mk(0,0,32'h0,        0,32'hAAAA0006,0,1,0,0));
    vecs.push_back(mk(0,0,32'h0,        0,EOF_W,4'b0001,1,1,1));
    vecs.push_back(mk(0,0,32'h0,        0,IDLE_W,IK,0,0,1));

    // Test 1: reset state, then idle fill with no input
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ready_a, txd_a, k_a, busy_a, done_a, seq_a},
          {1'b0, IDLE_W, IK, 1'b0, 1'b0, 8'h00});
    rst_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("idle_ready", 64'(ready_a), 64'(0));
      @(posedge clk); #1;
      check("idle_word", {txd_a, k_a}, {IDLE_W, IK});
    end

    // Tests 2, 3, 5 from the vector table
    foreach (vecs[i]) begin
      op_a = vecs[i].op; valid_a = vecs[i].valid; data_a = vecs[i].data;
      #1;
      check($sformatf("vec%0d_ready", i), 64'(ready_a), 64'(vecs[i].exp_ready));
      @(posedge clk); #1;
      check($sformatf("vec%0d_out", i), {txd_a, k_a, busy_a, done_a, seq_a},
            {vecs[i].exp_txd, vecs[i].exp_k, vecs[i].exp_busy, vecs[i].exp_done,
             vecs[i].exp_seq});
    end
    op_a = 1'b0; valid_a = 1'b0;

    // Test 6: clear seq with op_start, then 257 back-to-back L=0 frames
    op_a = 1'b1;
    @(posedge clk); #1;
    op_a = 1'b0;
    check("op_start_seq_clear", {txd_a, seq_a}, {IDLE_W, 8'h00});
    stream(1'b0, 257, 31'd0, 1'b0, 2000, 8'h01);

    // Test 4: CC bursts every 16 cycles in the middle of a long data run
    @(posedge clk); #1;
    rst_b = 1'b0;
    stream(1'b1, 1, 31'd39, 1'b1, 200, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
